// File: rtl/ifu_pkg.sv
// Shared IFU types and constants: line geometry, miss controller states,
// timeout/retry limits and the tag-to-line-address helper.
package ifu_pkg;

   localparam int ADDR_WIDTH     = 32;
   localparam int OFFSET_WIDTH   = 4;
   localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH;
   localparam int LINE_WIDTH     = 128;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int MAX_RETRIES    = 2;
   localparam int WAIT_CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
   localparam int RETRY_WIDTH    = $clog2(MAX_RETRIES + 1);

   typedef logic [TAG_WIDTH-1:0]  tag_t;
   typedef logic [LINE_WIDTH-1:0] line_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      FILL  = 3'd3,
      DRAIN = 3'd4
   } miss_state_t;

   function automatic addr_t line_addr(input tag_t tag);
      return {tag, {OFFSET_WIDTH{1'b0}}};
   endfunction

endpackage

// File: rtl/ifu_miss_pend_buf.sv
// Single-entry pending miss buffer. Drops tags that duplicate the in-flight
// or pending tag, and clears on flush.
module ifu_miss_pend_buf
   import ifu_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic push_i,
   input  tag_t tag_i,
   input  logic pop_i,
   input  logic act_valid_i,
   input  tag_t act_tag_i,
   output logic valid_o,
   output tag_t tag_o,
   output logic accept_o
);

   logic valid_q;
   logic valid_d;
   tag_t tag_q;
   tag_t tag_d;
   logic dup_s;
   logic free_s;

   // A slot being popped this cycle can take the new tag immediately.
   always_comb begin
      dup_s    = (act_valid_i && (tag_i == act_tag_i)) || (valid_q && (tag_i == tag_q));
      free_s   = !valid_q || pop_i;
      accept_o = push_i && !flush_i && !dup_s && free_s;
      valid_d  = valid_q;
      tag_d    = tag_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (accept_o) begin
         valid_d = 1'b1;
         tag_d   = tag_i;
      end else if (pop_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign valid_o = valid_q;
   assign tag_o   = tag_q;

endmodule

// File: rtl/ifu_miss_ctrl.sv
// Instruction-cache miss/refill controller: one outstanding line read with
// timeout-driven reissue, one pending miss slot and flush abort.
module ifu_miss_ctrl
   import ifu_pkg::*;
(
   input  logic                  Clock,
   input  logic                  Rst,
   input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
   input  logic                  cache_reqTagValidIn,
   input  logic                  flushIn,
   output logic [ADDR_WIDTH-1:0] mem_reqAddrOut,
   output logic                  mem_reqValidOut,
   input  logic                  mem_reqReadyIn,
   input  logic [LINE_WIDTH-1:0] mem_rspDataIn,
   input  logic                  mem_rspValidIn,
   output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
   output logic [LINE_WIDTH-1:0] cache_rspInsLineOut,
   output logic                  cache_rspInsLineValidOut,
   output logic                  busyOut,
   output logic                  timeoutErrOut,
   output logic [15:0]           missCountOut
);

   // Expiry one count early: the REQ cycle of the reissue completes the
   // TIMEOUT_CYCLES spacing between successive handshakes.
   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 2);
   localparam logic [RETRY_WIDTH-1:0]    RETRY_MAX = RETRY_WIDTH'(MAX_RETRIES);

   miss_state_t                state_q, state_d;
   tag_t                       tag_q, tag_d;
   line_t                      line_q, line_d;
   logic [WAIT_CNT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;
   logic [RETRY_WIDTH-1:0]     retry_q, retry_d;
   logic                       err_q, err_d;
   logic [15:0]                miss_cnt_q, miss_cnt_d;

   logic idle_take_s;
   logic err_set_s;
   logic pend_pop_s;
   logic pend_push_s;
   logic pend_valid_s;
   tag_t pend_tag_s;
   logic pend_accept_s;
   logic act_valid_s;

   assign act_valid_s = (state_q == REQ) || (state_q == WAIT) || (state_q == FILL);
   assign pend_push_s = cache_reqTagValidIn && !((state_q == IDLE) && !pend_valid_s);

   ifu_miss_pend_buf u_pend_buf (
      .clk_i       (Clock),
      .rst_ni      (Rst),
      .flush_i     (flushIn),
      .push_i      (pend_push_s),
      .tag_i       (cache_reqTagIn),
      .pop_i       (pend_pop_s),
      .act_valid_i (act_valid_s),
      .act_tag_i   (tag_q),
      .valid_o     (pend_valid_s),
      .tag_o       (pend_tag_s),
      .accept_o    (pend_accept_s)
   );

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      line_d      = line_q;
      wait_cnt_d  = wait_cnt_q;
      retry_d     = retry_q;
      idle_take_s = 1'b0;
      err_set_s   = 1'b0;
      pend_pop_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (flushIn) begin
               state_d = IDLE;
            end else if (pend_valid_s) begin
               pend_pop_s = 1'b1;
               tag_d      = pend_tag_s;
               retry_d    = '0;
               state_d    = REQ;
            end else if (cache_reqTagValidIn) begin
               idle_take_s = 1'b1;
               tag_d       = cache_reqTagIn;
               retry_d     = '0;
               state_d     = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (mem_reqReadyIn) begin
               wait_cnt_d = '0;
               state_d    = flushIn ? DRAIN : WAIT;
            end else if (flushIn) begin
               state_d = IDLE;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (flushIn) begin
               state_d = mem_rspValidIn ? IDLE : DRAIN;
            end else if (mem_rspValidIn) begin
               line_d  = mem_rspDataIn;
               state_d = FILL;
            end else if (wait_cnt_q == WAIT_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = REQ;
               end else begin
                  err_set_s = 1'b1;
                  retry_d   = '0;
                  state_d   = IDLE;
               end
            end else begin
               state_d = WAIT;
            end
         end
         FILL: begin
            retry_d = '0;
            state_d = IDLE;
         end
         DRAIN: begin
            if (mem_rspValidIn || (wait_cnt_q == WAIT_LAST)) begin
               state_d = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               state_d    = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      err_d = flushIn ? 1'b0 : (err_q | err_set_s);
      if ((idle_take_s || pend_accept_s) && (miss_cnt_q != 16'hFFFF)) begin
         miss_cnt_d = miss_cnt_q + 16'd1;
      end else begin
         miss_cnt_d = miss_cnt_q;
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state_q    <= IDLE;
         tag_q      <= '0;
         line_q     <= '0;
         wait_cnt_q <= '0;
         retry_q    <= '0;
         err_q      <= 1'b0;
         miss_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         line_q     <= line_d;
         wait_cnt_q <= wait_cnt_d;
         retry_q    <= retry_d;
         err_q      <= err_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign mem_reqValidOut          = (state_q == REQ);
   assign mem_reqAddrOut           = line_addr(tag_q);
   assign cache_rspTagOut          = tag_q;
   assign cache_rspInsLineOut      = line_q;
   assign cache_rspInsLineValidOut = (state_q == FILL) && !flushIn;
   assign busyOut                  = (state_q != IDLE) || pend_valid_s;
   assign timeoutErrOut            = err_q;
   assign missCountOut             = miss_cnt_q;

endmodule

// File: doc/ifu_miss_ctrl.md
Name: ifu_miss_ctrl

Overview:
Miss/refill controller between ifu_cache and the instruction memory port. It accepts miss tags from the cache and issues one line-read request at a time to memory over a valid/ready handshake. It waits for the response with a timeout and retry, then returns the line to the cache as a one-cycle fill. A single-entry pending buffer absorbs one further miss, and a flush input aborts all outstanding work.

Parameters:
ADDR_WIDTH, 32, byte address width
OFFSET_WIDTH, 4, line offset bits (16-byte line)
TAG_WIDTH, ADDR_WIDTH-OFFSET_WIDTH, line tag width
LINE_WIDTH, 128, instruction line width
TIMEOUT_CYCLES, 64, wait cycles before a request is reissued
MAX_RETRIES, 2, reissues before declaring an error

Ports:
Clock  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-low
cache_reqTagIn  in  TAG_WIDTH  miss tag from ifu_cache
cache_reqTagValidIn  in  1  miss tag valid
flushIn  in  1  abort in-flight and pending misses
mem_reqAddrOut  out  ADDR_WIDTH  line address {tag, OFFSET_WIDTH'0}
mem_reqValidOut  out  1  memory request valid
mem_reqReadyIn  in  1  memory accepts the request
mem_rspDataIn  in  LINE_WIDTH  returned line
mem_rspValidIn  in  1  response valid, single cycle
cache_rspTagOut  out  TAG_WIDTH  fill tag, to ifu_cache mem_rspTagIn
cache_rspInsLineOut  out  LINE_WIDTH  fill line
cache_rspInsLineValidOut  out  1  fill strobe, one cycle
busyOut  out  1  state!=IDLE or pending entry valid
timeoutErrOut  out  1  sticky retry-exhausted error
missCountOut  out  16  accepted misses, saturating

Behaviour:
- Reset (Rst low, async): state IDLE. All outputs 0, counters 0, pending buffer invalid.
- States: IDLE, REQ, WAIT, FILL, DRAIN.
- IDLE:
  - A valid pending entry has priority: move it to the in-flight tag and go to REQ.
  - Otherwise a cache_reqTagValidIn is latched as the in-flight tag and the FSM goes to REQ.
  - Latency: miss valid at edge N gives mem_reqValidOut=1 after edge N+1.
- REQ:
  - mem_reqValidOut=1 and mem_reqAddrOut stay stable until mem_reqValidOut and mem_reqReadyIn are both high at an edge.
  - Then go to WAIT and clear the wait counter.
- WAIT:
  - The wait counter increments every cycle.
  - mem_rspValidIn: latch the data and go to FILL.
  - Counter reaches TIMEOUT_CYCLES-1 with no response:
    - retries < MAX_RETRIES: retries++, go to REQ.
    - otherwise: set timeoutErrOut, drop the in-flight tag, go to IDLE.
- FILL:
  - cache_rspInsLineValidOut=1 for exactly one cycle, with cache_rspTagOut = in-flight tag and cache_rspInsLineOut = latched line.
  - Then go to IDLE and clear retries.
- DRAIN:
  - Discard the next mem_rspValidIn, or wait until timeout expiry, then go to IDLE.
  - No fill is produced and no retry is made.
- mem_rspValidIn outside WAIT/DRAIN is ignored.
- Miss acceptance while not in IDLE:
  - A new tag equal to the in-flight or pending tag is ignored.
  - A different tag is captured in the pending entry if it is empty; otherwise it is dropped (the cache re-requests).
- missCountOut increments on each accepted miss (IDLE latch or pending capture) and saturates at 16'hFFFF.
- flushIn, same edge, overrides everything:
  - The pending entry is invalidated and timeoutErrOut is cleared.
  - REQ goes to IDLE. A handshake completing on the same edge is treated as issued, so the FSM goes to DRAIN instead.
  - WAIT goes to DRAIN. A response arriving in the same cycle is consumed, and the FSM goes to IDLE.
  - FILL: cache_rspInsLineValidOut is gated to 0 in that cycle, then IDLE.
  - A miss presented in the same cycle as flushIn is ignored.
- Only one memory request is outstanding at any time. mem_reqValidOut never drops before the handshake completes.

Decomposition:
- ifu_pkg gains:
  - miss_state_t enum {IDLE, REQ, WAIT, FILL, DRAIN}
  - constants TIMEOUT_CYCLES and MAX_RETRIES
  - typedef tag_t (logic [TAG_WIDTH-1:0])
- The existing ADDR_WIDTH, OFFSET_WIDTH, TAG_WIDTH and LINE_WIDTH are reused.
- One sub-module, ifu_miss_pend_buf: the single-entry pending buffer with duplicate-tag filter and flush clear.

Test Plan:
1. Tag 28'h0000100, mem_reqReadyIn=1, response DEADBEEF×4 three cycles after the handshake:
   - mem_reqAddrOut=32'h1000.
   - One cycle of cache_rspInsLineValidOut with tag 28'h0000100 and the data.
   - missCountOut=1.
2. mem_reqReadyIn held low for 5 cycles: mem_reqValidOut stays 1 with a stable address; exactly one handshake occurs.
3. No response ever arrives:
   - 3 handshakes in total, spaced 64 cycles apart.
   - timeoutErrOut=1 and the FSM returns to IDLE.
   - A subsequent flushIn clears timeoutErrOut.
4. Tag 28'h1 is in flight; tags 28'h2, 28'h1 and 28'h3 arrive:
   - 28'h2 is pended; 28'h1 and 28'h3 are ignored.
   - After the fill of 28'h1, a request to address 32'h20 issues.
   - missCountOut=2.
5. flushIn in WAIT, response arriving 2 cycles later: no fill strobe, FSM returns to IDLE, busyOut=0.
6. Rst driven low mid-WAIT, between clock edges: all outputs are 0 immediately; the state is IDLE after release.
